// File: rtl/ss_op_sched.sv
// ss_op_sched: runs one DMA operation at a time on the shared m_* engine bus
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   desc_valid/ready/ctl    descriptor handshake and control word
//   dc                      control word broadcast to engines, 0 when idle
//   m_endn, m_src_getn      shared engine end flag and beat strobe (active-low)
//   abort_i                 software abort, honoured only while running
//   eng_rst                 one-hot soft reset to the engine that just ran
//   busy, done_o            op in flight, one-cycle completion pulse
//   status_code/len         result code and beat count of the last op
module ss_op_sched #(
  parameter int OP_BASE = 4,
  parameter int NUM_OPS = 4,
  parameter int TMO_W = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = '1,
  parameter int DRAIN_CYC = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [23:0]        desc_ctl,
  output logic [23:0]        dc,
  input  logic               m_endn,
  input  logic               m_src_getn,
  input  logic               abort_i,
  output logic [NUM_OPS-1:0] eng_rst,
  output logic               busy,
  output logic               done_o,
  output logic [1:0]         status_code,
  output logic [15:0]        status_len
);
  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam int DW = DRAIN_CYC > 2 ? $clog2(DRAIN_CYC) : 1;
  logic [2:0]         state_q, state_d;
  logic [23:0]        dc_q, dc_d;
  logic [NUM_OPS-1:0] sel_q, sel_d, eng_rst_q, eng_rst_d, new_sel;
  logic [15:0]        beats_q, beats_d, status_len_q, status_len_d;
  logic [TMO_W-1:0]   wd_q, wd_d;
  logic [DW-1:0]      drn_q, drn_d;
  logic [1:0]         code_q, code_d, status_code_q, status_code_d;
  logic               beat, run_exit;
  always_comb begin
    state_d = state_q;
    dc_d = dc_q;
    sel_d = sel_q;
    eng_rst_d = eng_rst_q;
    beats_d = beats_q;
    wd_d = wd_q;
    drn_d = drn_q;
    code_d = code_q;
    status_code_d = status_code_q;
    status_len_d = status_len_q;
    new_sel = desc_ctl[OP_BASE +: NUM_OPS];
    beat = !m_src_getn;
    run_exit = !m_endn || abort_i || wd_q == TMO_MAX;
    case (state_q)
      IDLE: if (desc_valid) begin
        sel_d = new_sel;
        // Anything but a single select bit is rejected without touching the bus
        if ($onehot(new_sel)) begin
          state_d = ARM;
          dc_d = desc_ctl;
        end else begin
          state_d = DONE;
          status_code_d = 2'b10;
          status_len_d = '0;
        end
      end
      ARM: begin
        state_d = RUN;
        beats_d = '0;
        wd_d = '0;
      end
      RUN: begin
        beats_d = (beat && beats_q != 16'hFFFF) ? beats_q + 16'd1 : beats_q;
        wd_d = beat ? '0 : wd_q + TMO_W'(1);
        if (run_exit) begin
          state_d = DRAIN;
          dc_d = '0;
          eng_rst_d = sel_q;
          drn_d = DW'(DRAIN_CYC - 1);
          code_d = !m_endn ? 2'b00 : abort_i ? 2'b11 : 2'b01;
        end
      end
      DRAIN: begin
        // Engine END state is sticky, so it stays in soft reset for the whole drain
        if (drn_q == '0) begin
          state_d = DONE;
          eng_rst_d = '0;
          status_code_d = code_q;
          status_len_d = beats_q;
        end else begin
          drn_d = drn_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      dc_q <= '0;
      sel_q <= '0;
      eng_rst_q <= '0;
      beats_q <= '0;
      wd_q <= '0;
      drn_q <= '0;
      code_q <= '0;
      status_code_q <= '0;
      status_len_q <= '0;
    end else begin
      state_q <= state_d;
      dc_q <= dc_d;
      sel_q <= sel_d;
      eng_rst_q <= eng_rst_d;
      beats_q <= beats_d;
      wd_q <= wd_d;
      drn_q <= drn_d;
      code_q <= code_d;
      status_code_q <= status_code_d;
      status_len_q <= status_len_d;
    end
  end
  assign desc_ready = state_q == IDLE && !wb_rst_i;
  assign dc = dc_q;
  assign eng_rst = eng_rst_q;
  assign busy = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign status_code = status_code_q;
  assign status_len = status_len_q;
endmodule

// File: tb/tb_ss_op_sched.sv
// tb_ss_op_sched: randomized and directed bench for ss_op_sched against an op-level reference model
module tb_ss_op_sched;
  localparam int TMO = 16;
  localparam int DRN = 2;
  logic        wb_clk_i = 0, wb_rst_i = 1;
  logic        desc_valid = 0, m_endn = 1, m_src_getn = 1, abort_i = 0;
  logic [23:0] desc_ctl = '0;
  logic        desc_ready, busy, done_o;
  logic [23:0] dc;
  logic [3:0]  eng_rst;
  logic [1:0]  status_code;
  logic [15:0] status_len;
  int checks = 0, errors = 0;
  ss_op_sched #(.OP_BASE(4), .NUM_OPS(4), .TMO_W(16), .TMO_MAX(16'd16), .DRAIN_CYC(DRN)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ctl(desc_ctl), .dc(dc), .m_endn(m_endn), .m_src_getn(m_src_getn), .abort_i(abort_i),
    .eng_rst(eng_rst), .busy(busy), .done_o(done_o), .status_code(status_code), .status_len(status_len)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask
  // mode 0: endn low at run cycle k; 1: abort at k; 2: beats for k cycles then stall; 3: abort+endn at k
  task automatic run_op(input logic [23:0] ctl, input int mode, input int k, input bit rnd,
                        input bit hold, input logic [23:0] nxt);
    logic [3:0] sel;
    logic [1:0] code;
    int beats, idle, cyc;
    bit ex, g, e, a;
    sel = ctl[7:4];
    desc_valid = 1;
    desc_ctl = ctl;
    check("ready", desc_ready, 1);
    tick();
    if (hold) desc_ctl = nxt; else desc_valid = 0;
    if ($countones(sel) != 1) begin
      check("bad_done", done_o, 1);
      check("bad_code", status_code, 2'b10);
      check("bad_len", status_len, 0);
      check("bad_dc", dc, 0);
      tick();
      check("bad_busy", busy, 0);
      check("bad_done_off", done_o, 0);
      return;
    end
    check("arm_dc", dc, ctl);
    check("arm_busy", busy, 1);
    check("arm_done", done_o, 0);
    m_src_getn = 1'($urandom_range(0, 1));
    tick();
    beats = 0; idle = 0; ex = 0; cyc = 0; code = 0;
    while (!ex && cyc < 300) begin
      g = (mode == 2 && cyc >= k) ? 1'b1 : rnd ? 1'($urandom_range(0, 1)) : (cyc >= k);
      e = !((mode == 0 || mode == 3) && cyc == k);
      a = (mode == 1 || mode == 3) && cyc == k;
      m_src_getn = g;
      m_endn = e;
      abort_i = a;
      check("run_dc", dc, ctl);
      if (hold) check("run_ready", desc_ready, 0);
      if (!e) begin ex = 1; code = 2'b00; end
      else if (a) begin ex = 1; code = 2'b11; end
      else if (idle == TMO) begin ex = 1; code = 2'b01; end
      if (!g) begin
        if (beats < 65535) beats++;
        idle = 0;
      end else idle++;
      tick();
      cyc++;
    end
    for (int i = 0; i < DRN; i++) begin
      m_src_getn = 1'($urandom_range(0, 1));
      m_endn = 1'($urandom_range(0, 1));
      abort_i = 1'($urandom_range(0, 1));
      check("drain_rst", eng_rst, sel);
      check("drain_dc", dc, 0);
      check("drain_done", done_o, 0);
      tick();
    end
    m_src_getn = 1; m_endn = 1; abort_i = 0;
    check("done", done_o, 1);
    check("code", status_code, code);
    check("len", status_len, beats);
    check("done_rst", eng_rst, 0);
    check("done_dc", dc, 0);
    tick();
    check("post_done", done_o, 0);
    check("post_ready", desc_ready, 1);
    check("hold_code", status_code, code);
    check("hold_len", status_len, beats);
  endtask
  initial begin
    logic [23:0] ctl;
    repeat (2) tick();
    check("rst_dc", dc, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", desc_ready, 0);
    check("rst_done", done_o, 0);
    check("rst_rst", eng_rst, 0);
    wb_rst_i = 0;
    tick();
    check("rst_code", status_code, 0);
    check("rst_len", status_len, 0);
    check("idle_ready", desc_ready, 1);
    abort_i = 1;
    tick();
    abort_i = 0;
    check("idle_abort", busy, 0);
    run_op(24'h000010, 0, 8, 0, 0, 0);
    run_op(24'h000030, 0, 0, 0, 0, 0);
    run_op(24'h000003, 0, 0, 0, 0, 0);
    run_op(24'h000040, 2, 3, 0, 0, 0);
    run_op(24'h000080, 1, 5, 0, 0, 0);
    run_op(24'h000020, 3, 5, 0, 0, 0);
    run_op(24'h000010, 0, 4, 0, 1, 24'h000020);
    run_op(24'h000020, 0, 2, 1, 0, 0);
    desc_valid = 1;
    desc_ctl = 24'h000080;
    tick();
    desc_valid = 0;
    tick();
    m_src_getn = 0;
    repeat (3) tick();
    #2 wb_rst_i = 1;
    #1;
    check("arst_dc", dc, 0);
    check("arst_rst", eng_rst, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", desc_ready, 0);
    m_src_getn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_done", done_o, 0);
    end
    wb_rst_i = 0;
    tick();
    check("arst_ready_back", desc_ready, 1);
    run_op(24'h000010, 0, 6, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      ctl = 24'($urandom);
      if ($urandom_range(0, 4) != 0) ctl[7:4] = 4'b0001 << $urandom_range(0, 3);
      run_op(ctl, ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1),
             $urandom_range(0, 12), 1, $urandom_range(0, 3) == 0, 24'($urandom) & 24'hFFFF0F | 24'h000040);
    end
    desc_valid = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
